clock_set_controller: RTL and testbench
=======================================

# clock_set_controller

Run/pause/time-set controller for the digital clock. It conditions three push-buttons and generates the 1 Hz count enable. It sequences a four-state mode machine and owns the registered minutes/seconds values that feed the seconds/minutes decoders and the display scan mux. It replaces the free-running seconds/minutes counter with a user-controllable one.

## Interface
- CLK_HZ, 100_000_000: clock cycles per second; prescaler terminal count is CLK_HZ-1.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level change.
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_run  in  1  raw asynchronous button: start/stop.
- btn_mode  in  1  raw asynchronous button: step through set modes.
- btn_up  in  1  raw asynchronous button: increment the selected field.
- seconds  out  6  registered seconds, 0..59.
- minutes  out  6  registered minutes, 0..59.
- mode  out  2  registered state encoding: RUN=0, PAUSE=1, SET_MIN=2, SET_SEC=3.
- blank_min  out  1  blank the minute digits; used for blinking while the field is set.
- blank_sec  out  1  blank the second digits.

## Operation
- Reset, or reset asserted mid-operation, forces the following on the next edge:
  - mode=PAUSE, seconds=0, minutes=0, blank_min=blank_sec=0.
  - Prescaler, blink counter and all debounce state cleared.
  - Debounced levels forced to 0, so a button held through reset yields no press until it is released and pressed again.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: the debounced level updates after DEBOUNCE_CYCLES consecutive cycles in which the synchronized level differs from the current debounced level. Any bounce resets the count.
  - A press is a 1-cycle pulse on the debounced 0→1 edge. Releases produce no event.
- State transitions:
  - PAUSE + run → RUN.
  - RUN + run → PAUSE.
  - PAUSE + mode → SET_MIN.
  - SET_MIN + mode → SET_SEC.
  - SET_SEC + mode → PAUSE.
  - SET_MIN or SET_SEC + run → RUN.
  - RUN + mode: ignored.
- Simultaneous run and mode presses in the same cycle: run wins and mode is discarded.
- Prescaler counts only in RUN and emits tick when count = CLK_HZ-1, then wraps to 0. It clears whenever mode ≠ RUN, so the first tick comes exactly CLK_HZ cycles after entering RUN.
- On tick in RUN:
  - seconds+1.
  - At seconds=59: seconds→0 and minutes+1.
  - 59:59 → 00:00.
- A tick and a run press in the same cycle: the increment is applied and mode becomes PAUSE, both on the same edge.
- up press:
  - In SET_MIN: minutes+1, wrapping 59→0.
  - In SET_SEC: seconds+1, wrapping 59→0, with no carry into minutes.
  - Ignored in RUN and PAUSE.
- Blink: a counter of period CLK_HZ runs only in SET states and clears on entering either SET state.
  - blank_min=1 in SET_MIN while the counter ≥ CLK_HZ/2.
  - blank_sec=1 in SET_SEC while the counter ≥ CLK_HZ/2.
  - Both are 0 in all other states.
- All arithmetic is 6-bit unsigned. Values above 59 are unreachable.

## Timing
- Raw button rising edge, held stable, to press pulse: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 edge-detect cycle.
- Press pulse to mode/seconds/minutes change: the update is visible after the next rising edge (1 cycle).
- Tick to count change: visible after the next rising edge.
- At most one press per button per debounced edge. Back-to-back presses need a debounced release in between, so they are at least 2·DEBOUNCE_CYCLES apart.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package clock_ctrl_pkg:
  - State enum: RUN, PAUSE, SET_MIN, SET_SEC with the fixed 2-bit encoding above.
  - Constants: MAX_SEC=59, MAX_MIN=59.
- Sub-module button_conditioner (synchronizer, debounce, rising-edge pulse; parameter DEBOUNCE_CYCLES), instantiated three times.
- Prescaler, blink counter, FSM and the time registers live in the top module.

## Test plan
All scenarios use CLK_HZ=10, DEBOUNCE_CYCLES=4.
- Reset, then hold btn_run high for 20 cycles → one press; mode=RUN 8 cycles after the raw rise. seconds=1 exactly 10 cycles after entering RUN, and seconds=5 after 50 cycles.
- Preload 59:59 via SET states, then RUN → after one tick, minutes=0, seconds=0.
- From PAUSE press mode, then 3× up → mode=SET_MIN, minutes=3. blank_min toggles with a 5-cycle half-period and blank_sec stays 0.
- In SET_SEC at seconds=59, press up → seconds=0, minutes unchanged. A following mode press → PAUSE.
- Bounce btn_mode (1,0,1,0 every 2 cycles) for 20 cycles, then hold low → no press and mode unchanged. Press run and mode in the same cycle from PAUSE → mode=RUN.
- Assert reset for 1 cycle mid-RUN at 12:34 with btn_up held → next edge gives 00:00, PAUSE, blanks 0. The held btn_up yields no press until it is released and pressed again.

Source files
------------

// File: rtl/clock_set_controller_pkg.sv
// Shared types and constants for the run/pause/time-set clock controller.
package clock_ctrl_pkg;

  // Mode encoding is visible on the mode output, so the values are fixed.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PAUSE   = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_t;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;

  // Increment with wrap to zero after max_v.
  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max_v);
    return (v == max_v) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic is_set(input state_t s);
    return (s == SET_MIN) || (s == SET_SEC);
  endfunction

endpackage

// File: rtl/clock_set_controller_if.sv
// Button inputs and display-facing outputs of the clock controller.
interface clock_set_controller_if;
  logic       btn_run;
  logic       btn_mode;
  logic       btn_up;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [1:0] mode;
  logic       blank_min;
  logic       blank_sec;

  modport master (
    output btn_run, btn_mode, btn_up,
    input  seconds, minutes, mode, blank_min, blank_sec
  );

  modport slave (
    input  btn_run, btn_mode, btn_up,
    output seconds, minutes, mode, blank_min, blank_sec
  );
endinterface

// File: rtl/clock_set_controller_button_conditioner.sv
// Synchronizes, debounces and edge-detects one raw push-button into a 1-cycle press pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic             level, level_d;
  logic             block;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer for the asynchronous pin.
  // NOTE: these flops are intentionally not reset so they keep tracking the pin
  // while reset is held; that is how a button held through reset is recognized.
  always_ff @(posedge clock) begin
    sync1 <= btn;
    sync2 <= sync1;
  end

  // Debounce counter, hold-off after reset, and rising-edge press pulse.
  // NOTE: every sequential assignment uses <= so all flops see pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      block   <= 1'b1;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d & ~block;
      // Presses are re-enabled only once the button is seen released.
      if (!level && !sync2) block <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Run/pause/time-set controller: button conditioning, 1 Hz prescaler, mode FSM,
// minutes/seconds registers and set-mode blink.
module clock_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic                   clock,
  input logic                   reset,
  clock_set_controller_if.slave bus
);
  localparam int               PRE_W    = $clog2(CLK_HZ);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0] HALF     = PRE_W'(CLK_HZ / 2);

  logic             run_p, mode_p, up_p;
  state_t           state, state_next;
  logic [PRE_W-1:0] presc;
  logic [PRE_W-1:0] blink, blink_next;
  logic             tick;
  logic [5:0]       sec, min;
  logic             blank_min_q, blank_sec_q;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clock(clock), .reset(reset), .btn(bus.btn_run), .press(run_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clock(clock), .reset(reset), .btn(bus.btn_mode), .press(mode_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clock(clock), .reset(reset), .btn(bus.btn_up), .press(up_p));

  assign tick = (state == RUN) && (presc == PRE_LAST);

  // Next mode: run press dominates, mode press steps PAUSE -> SET_MIN -> SET_SEC -> PAUSE.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    if (run_p) begin
      state_next = (state == RUN) ? PAUSE : RUN;
    end else if (mode_p) begin
      case (state)
        PAUSE:   state_next = SET_MIN;
        SET_MIN: state_next = SET_SEC;
        SET_SEC: state_next = PAUSE;
        default: state_next = state;
      endcase
    end
  end

  // Blink phase: runs only while staying in a SET state, restarts on entry.
  always_comb begin
    blink_next = '0;
    if (is_set(state_next) && (state_next == state))
      blink_next = (blink == PRE_LAST) ? '0 : blink + 1'b1;
  end

  // Mode register.
  always_ff @(posedge clock) begin
    if (reset) state <= PAUSE;
    else       state <= state_next;
  end

  // 1 Hz prescaler, held at zero outside RUN.
  always_ff @(posedge clock) begin
    if (reset || state != RUN) presc <= '0;
    else if (presc == PRE_LAST) presc <= '0;
    else                        presc <= presc + 1'b1;
  end

  // Blink counter and registered blanking outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      blink       <= '0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      blink       <= blink_next;
      blank_min_q <= (state_next == SET_MIN) && (blink_next >= HALF);
      blank_sec_q <= (state_next == SET_SEC) && (blink_next >= HALF);
    end
  end

  // Time registers: count on tick in RUN, or step the selected field on up.
  always_ff @(posedge clock) begin
    if (reset) begin
      sec <= '0;
      min <= '0;
    end else if (tick) begin
      sec <= inc_wrap(sec, MAX_SEC);
      if (sec == MAX_SEC) min <= inc_wrap(min, MAX_MIN);
    end else if (up_p && state == SET_MIN) begin
      min <= inc_wrap(min, MAX_MIN);
    end else if (up_p && state == SET_SEC) begin
      sec <= inc_wrap(sec, MAX_SEC);
    end
  end

  assign bus.seconds   = sec;
  assign bus.minutes   = min;
  assign bus.mode      = state;
  assign bus.blank_min = blank_min_q;
  assign bus.blank_sec = blank_sec_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller with a small clock and debounce count.
module tb_clock_set_controller;
  import clock_ctrl_pkg::*;

  localparam int CLK_HZ   = 10;
  localparam int DEB      = 4;
  localparam int PRESS_AT = DEB + 4;  // raw-high edges until the press takes effect
  localparam int REARM    = DEB + 3;  // raw-low edges that count as a full release
  localparam int HOLD     = DEB + 6;
  localparam int GAP      = DEB + 6;

  logic clock = 1'b0;
  logic reset;

  clock_set_controller_if bus ();

  clock_set_controller #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model (time-level view of the spec) ----------------
  state_t m_mode;
  int     m_sec, m_min;
  int     m_run_cnt;   // edges spent in RUN since entry
  int     m_set_cnt;   // edges spent in the current SET state since entry
  int     hi[3], lo[3];
  bit     armed[3];
  bit     model_on = 1'b0;

  function automatic state_t next_mode(input state_t m, input bit run, input bit mode);
    if (run) return (m == RUN) ? PAUSE : RUN;
    if (!mode) return m;
    case (m)
      PAUSE:   return SET_MIN;
      SET_MIN: return SET_SEC;
      SET_SEC: return PAUSE;
      default: return m;
    endcase
  endfunction

  task automatic model_edge(input bit rst, input bit [2:0] raw);
    bit [2:0] press;
    bit       tick;
    state_t   nxt;
    int       t;
    for (int b = 0; b < 3; b++) begin
      hi[b] = raw[b] ? hi[b] + 1 : 0;
      lo[b] = raw[b] ? 0 : lo[b] + 1;
      if (lo[b] >= REARM) armed[b] = 1'b1;
      press[b] = armed[b] && (hi[b] == PRESS_AT);
    end
    if (rst) begin
      model_on = 1'b1;
      for (int b = 0; b < 3; b++) armed[b] = !raw[b];
      m_mode = PAUSE; m_sec = 0; m_min = 0; m_run_cnt = 0; m_set_cnt = 0;
      return;
    end
    tick = (m_mode == RUN) && (m_run_cnt % CLK_HZ == CLK_HZ - 1);
    if (tick) begin
      t     = (m_min * 60 + m_sec + 1) % 3600;
      m_min = t / 60;
      m_sec = t % 60;
    end
    if (press[2] && m_mode == SET_MIN) m_min = (m_min + 1) % 60;
    if (press[2] && m_mode == SET_SEC) m_sec = (m_sec + 1) % 60;
    nxt       = next_mode(m_mode, press[0], press[1]);
    m_run_cnt = (nxt == RUN && m_mode == RUN) ? m_run_cnt + 1 : 0;
    m_set_cnt = (nxt == m_mode && (nxt == SET_MIN || nxt == SET_SEC)) ? m_set_cnt + 1 : 0;
    m_mode    = nxt;
  endtask

  function automatic int model_pack();
    bit bm, bs;
    bm = (m_mode == SET_MIN) && ((m_set_cnt % CLK_HZ) >= CLK_HZ / 2);
    bs = (m_mode == SET_SEC) && ((m_set_cnt % CLK_HZ) >= CLK_HZ / 2);
    return (int'(m_mode) << 14) | (m_min << 8) | (m_sec << 2) | (int'(bm) << 1) | int'(bs);
  endfunction

  // One clock: sample inputs, advance model, compare at the falling edge.
  task automatic step();
    bit [2:0] raw;
    bit       rst;
    raw = {bus.btn_up, bus.btn_mode, bus.btn_run};
    rst = reset;
    @(posedge clock);
    model_edge(rst, raw);
    @(negedge clock);
    if (model_on)
      check("cycle{mode,min,sec,bm,bs}",
            int'({bus.mode, bus.minutes, bus.seconds, bus.blank_min, bus.blank_sec}),
            model_pack());
  endtask

  task automatic set_btns(input bit r, input bit m, input bit u);
    bus.btn_run  = r;
    bus.btn_mode = m;
    bus.btn_up   = u;
  endtask

  task automatic press_btns(input bit r, input bit m, input bit u, input int hold, input int gap);
    set_btns(r, m, u);
    repeat (hold) step();
    set_btns(0, 0, 0);
    repeat (gap) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  // ---------------- table of multi-press sequences ----------------
  typedef struct {
    bit     run, mode, up;
    int     reps;
    state_t exp_mode;
    int     exp_min, exp_sec;
  } vec_t;

  localparam int NTBL = 13;
  vec_t tbl[NTBL];

  initial begin
    tbl[0]  = '{run:0, mode:0, up:1, reps:3,  exp_mode:SET_MIN, exp_min:3,  exp_sec:0};
    tbl[1]  = '{run:0, mode:0, up:1, reps:56, exp_mode:SET_MIN, exp_min:59, exp_sec:0};
    tbl[2]  = '{run:0, mode:1, up:0, reps:1,  exp_mode:SET_SEC, exp_min:59, exp_sec:0};
    tbl[3]  = '{run:0, mode:0, up:1, reps:59, exp_mode:SET_SEC, exp_min:59, exp_sec:59};
    tbl[4]  = '{run:0, mode:0, up:1, reps:1,  exp_mode:SET_SEC, exp_min:59, exp_sec:0};
    tbl[5]  = '{run:0, mode:0, up:1, reps:59, exp_mode:SET_SEC, exp_min:59, exp_sec:59};
    tbl[6]  = '{run:0, mode:1, up:0, reps:1,  exp_mode:PAUSE,   exp_min:59, exp_sec:59};
    tbl[7]  = '{run:1, mode:1, up:0, reps:1,  exp_mode:RUN,     exp_min:0,  exp_sec:0};
    tbl[8]  = '{run:1, mode:0, up:0, reps:1,  exp_mode:PAUSE,   exp_min:0,  exp_sec:1};
    tbl[9]  = '{run:0, mode:1, up:0, reps:1,  exp_mode:SET_MIN, exp_min:0,  exp_sec:1};
    tbl[10] = '{run:0, mode:0, up:1, reps:12, exp_mode:SET_MIN, exp_min:12, exp_sec:1};
    tbl[11] = '{run:0, mode:1, up:0, reps:1,  exp_mode:SET_SEC, exp_min:12, exp_sec:1};
    tbl[12] = '{run:0, mode:0, up:1, reps:33, exp_mode:SET_SEC, exp_min:12, exp_sec:34};

    for (int b = 0; b < 3; b++) begin
      hi[b] = 0; lo[b] = 0; armed[b] = 1'b0;
    end
    set_btns(0, 0, 0);
    reset = 1'b0;
    @(negedge clock);

    // Reset state.
    do_reset(3);
    check("reset.mode",      int'(bus.mode), int'(PAUSE));
    check("reset.seconds",   int'(bus.seconds), 0);
    check("reset.minutes",   int'(bus.minutes), 0);
    check("reset.blank_min", int'(bus.blank_min), 0);
    check("reset.blank_sec", int'(bus.blank_sec), 0);

    // Held run button: press latency and first ticks.
    set_btns(1, 0, 0);
    for (int e = 1; e <= 60; e++) begin
      step();
      if (e == 20) set_btns(0, 0, 0);
      if (e == 7)  check("run_latency.before", int'(bus.mode), int'(PAUSE));
      if (e == 8)  check("run_latency.at",     int'(bus.mode), int'(RUN));
      if (e == 17) check("first_tick.before",  int'(bus.seconds), 0);
      if (e == 18) check("first_tick.at",      int'(bus.seconds), 1);
      if (e == 57) check("tick5.before",       int'(bus.seconds), 4);
      if (e == 58) check("tick5.at",           int'(bus.seconds), 5);
    end
    press_btns(1, 0, 0, HOLD, GAP);
    check("run_to_pause.mode", int'(bus.mode), int'(PAUSE));

    // Enter SET_MIN and watch the blink phase.
    do_reset(2);
    set_btns(0, 1, 0);
    repeat (8) step();
    check("set_min.mode", int'(bus.mode), int'(SET_MIN));
    for (int j = 1; j <= 20; j++) begin
      step();
      if (j == 2) set_btns(0, 0, 0);
      check($sformatf("blink_min[%0d]", j), int'(bus.blank_min), int'((j % 10) >= 5));
      check($sformatf("blink_sec[%0d]", j), int'(bus.blank_sec), 0);
    end

    // Table: preload, wrap, simultaneous run+mode, tick coincident with run press.
    for (int i = 0; i < NTBL; i++) begin
      for (int r = 0; r < tbl[i].reps; r++)
        press_btns(tbl[i].run, tbl[i].mode, tbl[i].up, HOLD, GAP);
      check($sformatf("table[%0d].mode", i),    int'(bus.mode),    int'(tbl[i].exp_mode));
      check($sformatf("table[%0d].minutes", i), int'(bus.minutes), tbl[i].exp_min);
      check($sformatf("table[%0d].seconds", i), int'(bus.seconds), tbl[i].exp_sec);
    end

    // Bouncing mode button in SET_SEC must not register.
    for (int k = 0; k < 5; k++) begin
      set_btns(0, 1, 0); repeat (2) step();
      set_btns(0, 0, 0); repeat (2) step();
    end
    repeat (10) step();
    check("bounce.mode",    int'(bus.mode),    int'(SET_SEC));
    check("bounce.seconds", int'(bus.seconds), 34);

    // Reset mid-RUN at 12:34 with run and up held through it.
    set_btns(1, 0, 0);
    repeat (8) step();
    check("midrun.mode",    int'(bus.mode),    int'(RUN));
    check("midrun.minutes", int'(bus.minutes), 12);
    check("midrun.seconds", int'(bus.seconds), 34);
    set_btns(1, 0, 1);
    repeat (2) step();
    do_reset(1);
    check("midreset.mode",      int'(bus.mode),      int'(PAUSE));
    check("midreset.minutes",   int'(bus.minutes),   0);
    check("midreset.seconds",   int'(bus.seconds),   0);
    check("midreset.blank_min", int'(bus.blank_min), 0);
    check("midreset.blank_sec", int'(bus.blank_sec), 0);
    repeat (20) step();
    check("held_through_reset.mode", int'(bus.mode), int'(PAUSE));
    set_btns(0, 0, 0);
    repeat (GAP) step();
    press_btns(0, 1, 0, HOLD, GAP);
    press_btns(0, 0, 1, HOLD, GAP);
    check("repress.mode",    int'(bus.mode),    int'(SET_MIN));
    check("repress.minutes", int'(bus.minutes), 1);

    // Randomized clean and bouncy presses against the model.
    for (int i = 0; i < 60; i++) begin
      bit r, m, u;
      int combo;
      combo = $urandom_range(0, 5);
      r = (combo == 0) || (combo == 3);
      m = (combo == 1) || (combo == 3) || (combo == 4);
      u = (combo == 2) || (combo == 4);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        set_btns(r, m, u); repeat ($urandom_range(1, 2)) step();
        set_btns(0, 0, 0); repeat ($urandom_range(1, 2)) step();
      end
      press_btns(r, m, u, $urandom_range(PRESS_AT, PRESS_AT + 8), $urandom_range(REARM, REARM + 10));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
